// File: rtl/ram_arb_if.sv
// rtl/ram_arb_if.sv - requester, RAM and status signals of the program/data RAM arbiter
interface ram_arb_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          run;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic          ldr_req;
  logic          ldr_we;
  logic [AW-1:0] ldr_addr;
  logic [DW-1:0] ldr_wdata;
  logic          ldr_lock;
  logic          ldr_ack;
  logic [DW-1:0] ldr_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [1:0]    owner;

  // requesters plus RAM macro side
  modport master (
    output run,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata,
    output ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_lock,
    input  ldr_ack, ldr_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  owner
  );

  // arbiter side
  modport slave (
    input  run,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata,
    input  ldr_req, ldr_we, ldr_addr, ldr_wdata, ldr_lock,
    output ldr_ack, ldr_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output owner
  );
endinterface

// File: rtl/ram_arb.sv
// rtl/ram_arb.sv - CPU / front-panel loader arbiter for the single-port program RAM
module ram_arb #(
  parameter int AW     = 8,
  parameter int DW     = 8,
  parameter int STARVE = 4
) (
  input  logic          clk,
  input  logic          clr_n,
  ram_arb_if.slave      bus
);

  typedef enum logic [1:0] {IDLE, ACC, RSP, ACK} state_t;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE);
  localparam logic [1:0] OWN_NONE   = 2'b00;
  localparam logic [1:0] OWN_CPU    = 2'b01;
  localparam logic [1:0] OWN_LDR    = 2'b10;

  state_t     state;
  logic [3:0] starve_cnt;
  logic       lock_flag;
  logic       wr_q;      // current access is a write; mem_we itself drops after ACC
  logic       lock_win;
  logic       ldr_win;
  logic       cpu_win;

  // IDLE arbitration; a lock only holds while the loader keeps both req and lock up
  always_comb begin
    lock_win = lock_flag & bus.ldr_lock & bus.ldr_req;
    ldr_win  = 1'b0;
    cpu_win  = 1'b0;
    if (lock_win) begin
      ldr_win = 1'b1;
    end else if (!bus.run) begin
      ldr_win = bus.ldr_req;
    end else if (bus.cpu_req && bus.ldr_req && starve_cnt == STARVE_MAX) begin
      ldr_win = 1'b1;
    end else if (bus.cpu_req) begin
      cpu_win = 1'b1;
    end else begin
      ldr_win = bus.ldr_req;
    end
  end

  // access sequencer: IDLE -> ACC -> RSP -> ACK -> IDLE, all outputs registered
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state         <= IDLE;
      starve_cnt    <= '0;
      lock_flag     <= 1'b0;
      wr_q          <= 1'b0;
      bus.owner     <= OWN_NONE;
      bus.cpu_ack   <= 1'b0;
      bus.ldr_ack   <= 1'b0;
      bus.cpu_rdata <= '0;
      bus.ldr_rdata <= '0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!bus.ldr_req) starve_cnt <= '0;
          if (!bus.ldr_req || !bus.ldr_lock) lock_flag <= 1'b0;
          if (ldr_win) begin
            state         <= ACC;
            bus.owner     <= OWN_LDR;
            bus.mem_en    <= 1'b1;
            bus.mem_we    <= bus.ldr_we;
            wr_q          <= bus.ldr_we;
            bus.mem_addr  <= bus.ldr_addr[AW-1:0];
            bus.mem_wdata <= bus.ldr_wdata[DW-1:0];
            starve_cnt    <= '0;
            lock_flag     <= bus.ldr_lock;
          end else if (cpu_win) begin
            state         <= ACC;
            bus.owner     <= OWN_CPU;
            bus.mem_en    <= 1'b1;
            bus.mem_we    <= bus.cpu_we;
            wr_q          <= bus.cpu_we;
            bus.mem_addr  <= bus.cpu_addr[AW-1:0];
            bus.mem_wdata <= bus.cpu_wdata[DW-1:0];
            if (bus.ldr_req && starve_cnt != STARVE_MAX) starve_cnt <= starve_cnt + 4'd1;
          end else begin
            bus.owner <= OWN_NONE;
          end
        end
        ACC: begin
          state      <= RSP;
          bus.mem_en <= 1'b0;
          bus.mem_we <= 1'b0;
        end
        RSP: begin
          state <= ACK;
          if (bus.owner == OWN_CPU) begin
            bus.cpu_ack <= 1'b1;
            if (!wr_q) bus.cpu_rdata <= bus.mem_rdata[DW-1:0];
          end else begin
            bus.ldr_ack <= 1'b1;
            if (!wr_q) bus.ldr_rdata <= bus.mem_rdata[DW-1:0];
          end
        end
        default: begin
          state       <= IDLE;
          bus.cpu_ack <= 1'b0;
          bus.ldr_ack <= 1'b0;
          bus.owner   <= OWN_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arb.sv
// tb/tb_ram_arb.sv - directed self-checking bench for ram_arb
module tb_ram_arb;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int STARVE = 4;

  logic clk = 1'b0;
  logic clr_n;
  int   total = 0;
  int   bad = 0;

  logic          pre_we;
  logic [AW-1:0] pre_addr;
  logic [DW-1:0] pre_data;
  logic [DW-1:0] ram [0:255];

  always #5 clk = ~clk;

  ram_arb_if #(.AW(AW), .DW(DW)) bus ();

  ram_arb #(.AW(AW), .DW(DW), .STARVE(STARVE)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  // synchronous RAM model with a preload port
  always @(posedge clk) begin
    if (pre_we) begin
      ram[pre_addr] <= pre_data;
    end else if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= ram[bus.mem_addr];
    end
  end

  // drive one request, count cycles to its ack (-1 on timeout), then return in IDLE
  task automatic xfer(input bit ldr, input bit we, input logic [7:0] addr, input logic [7:0] wdata,
                      output int lat, output int en_cnt, output int we_cnt,
                      output logic [1:0] own, output logic ack_after);
    if (ldr) begin
      bus.ldr_req = 1'b1; bus.ldr_we = we; bus.ldr_addr = addr; bus.ldr_wdata = wdata;
    end else begin
      bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
    end
    lat = -1; en_cnt = 0; we_cnt = 0; own = 2'b00;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (bus.mem_en === 1'b1) begin en_cnt++; own = bus.owner; end
      if (bus.mem_we === 1'b1) we_cnt++;
      if ((ldr ? bus.ldr_ack : bus.cpu_ack) === 1'b1) begin lat = i; break; end
    end
    if (ldr) bus.ldr_req = 1'b0; else bus.cpu_req = 1'b0;
    @(negedge clk);
    ack_after = ldr ? bus.ldr_ack : bus.cpu_ack;
  endtask

  task automatic test_reset;
    clr_n = 1'b0;
    bus.run = 1'b0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.ldr_req = 1'b0; bus.ldr_we = 1'b0; bus.ldr_addr = '0; bus.ldr_wdata = '0; bus.ldr_lock = 1'b0;
    pre_we = 1'b1; pre_addr = 8'h05; pre_data = 8'h3C;
    repeat (3) @(negedge clk);
    pre_we = 1'b0;
    total++; if (bus.owner !== 2'b00) begin bad++; $display("FAIL reset_owner got=%h exp=00", bus.owner); end
    total++; if ({bus.mem_en, bus.mem_we, bus.cpu_ack, bus.ldr_ack} !== 4'b0000) begin
      bad++; $display("FAIL reset_strobes got=%b exp=0000", {bus.mem_en, bus.mem_we, bus.cpu_ack, bus.ldr_ack}); end
    total++; if ({bus.mem_addr, bus.mem_wdata} !== 16'h0000) begin
      bad++; $display("FAIL reset_mem_bus got=%h exp=0000", {bus.mem_addr, bus.mem_wdata}); end
    total++; if ({bus.cpu_rdata, bus.ldr_rdata} !== 16'h0000) begin
      bad++; $display("FAIL reset_rdata got=%h exp=0000", {bus.cpu_rdata, bus.ldr_rdata}); end
    clr_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_cpu_read;
    bus.run = 1'b1;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 8'h05;
    @(negedge clk);
    total++; if ({bus.mem_en, bus.mem_we, bus.mem_addr, bus.owner} !== {1'b1, 1'b0, 8'h05, 2'b01}) begin
      bad++; $display("FAIL cpu_rd_acc got=%h exp=%h", {bus.mem_en, bus.mem_we, bus.mem_addr, bus.owner}, {1'b1, 1'b0, 8'h05, 2'b01}); end
    @(negedge clk);
    total++; if ({bus.mem_en, bus.cpu_ack, bus.owner} !== 4'b0001) begin
      bad++; $display("FAIL cpu_rd_rsp got=%b exp=0001", {bus.mem_en, bus.cpu_ack, bus.owner}); end
    @(negedge clk);
    total++; if (bus.cpu_ack !== 1'b1) begin bad++; $display("FAIL cpu_rd_ack got=%b exp=1", bus.cpu_ack); end
    total++; if (bus.cpu_rdata !== 8'h3C) begin bad++; $display("FAIL cpu_rd_data got=%h exp=3c", bus.cpu_rdata); end
    bus.cpu_req = 1'b0;
    @(negedge clk);
    total++; if ({bus.cpu_ack, bus.owner, bus.mem_en} !== 4'b0000) begin
      bad++; $display("FAIL cpu_rd_idle got=%b exp=0000", {bus.cpu_ack, bus.owner, bus.mem_en}); end
  endtask

  task automatic test_ldr_write_cpu_read;
    int lat, en_cnt, we_cnt;
    logic [1:0] own;
    logic ack_after;
    bus.run = 1'b0;
    xfer(1'b1, 1'b1, 8'h0F, 8'hA7, lat, en_cnt, we_cnt, own, ack_after);
    total++; if (lat !== 3) begin bad++; $display("FAIL ldr_wr_latency got=%0d exp=3", lat); end
    total++; if (we_cnt !== 1 || en_cnt !== 1) begin
      bad++; $display("FAIL ldr_wr_strobes got=we%0d/en%0d exp=we1/en1", we_cnt, en_cnt); end
    total++; if (own !== 2'b10) begin bad++; $display("FAIL ldr_wr_owner got=%b exp=10", own); end
    total++; if (ack_after !== 1'b0) begin bad++; $display("FAIL ldr_ack_width got=%b exp=0", ack_after); end
    bus.run = 1'b1;
    xfer(1'b0, 1'b0, 8'h0F, 8'h00, lat, en_cnt, we_cnt, own, ack_after);
    total++; if (lat !== 3 || we_cnt !== 0) begin
      bad++; $display("FAIL cpu_rd_after_ldr got=lat%0d/we%0d exp=lat3/we0", lat, we_cnt); end
    total++; if (bus.cpu_rdata !== 8'hA7) begin bad++; $display("FAIL cpu_rd_ldr_data got=%h exp=a7", bus.cpu_rdata); end
    total++; if (bus.ldr_rdata !== 8'h00) begin bad++; $display("FAIL ldr_rdata_kept got=%h exp=00", bus.ldr_rdata); end
  endtask

  task automatic test_program_block;
    int en_seen, ack_seen, lat;
    bus.run = 1'b0;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 8'h05;
    en_seen = 0; ack_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.mem_en === 1'b1) en_seen++;
      if (bus.cpu_ack === 1'b1) ack_seen++;
    end
    total++; if (en_seen !== 0 || ack_seen !== 0) begin
      bad++; $display("FAIL prog_block got=en%0d/ack%0d exp=en0/ack0", en_seen, ack_seen); end
    bus.run = 1'b1;
    lat = -1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (bus.cpu_ack === 1'b1) begin lat = i; break; end
    end
    total++; if (lat !== 3) begin bad++; $display("FAIL prog_release_latency got=%0d exp=3", lat); end
    bus.cpu_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_starve;
    int exp_seq [10] = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2};
    int seq [10];
    int when [10];
    int n, t;
    bit acked;
    bus.run = 1'b1; bus.ldr_lock = 1'b0;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 8'h05;
    bus.ldr_req = 1'b1; bus.ldr_we = 1'b0; bus.ldr_addr = 8'h05;
    n = 0;
    for (t = 0; t < 80 && n < 10; t++) begin
      @(negedge clk);
      if (bus.mem_en === 1'b1) begin seq[n] = int'(bus.owner); when[n] = t; n++; end
    end
    total++; if (n !== 10) begin bad++; $display("FAIL starve_grant_count got=%0d exp=10", n); end
    for (int i = 0; i < n; i++) begin
      total++; if (seq[i] !== exp_seq[i]) begin
        bad++; $display("FAIL starve_grant_%0d got=%0d exp=%0d", i, seq[i], exp_seq[i]); end
    end
    if (n == 10) begin
      total++; if (when[9] - when[0] !== 36) begin
        bad++; $display("FAIL b2b_spacing got=%0d exp=36", when[9] - when[0]); end
    end
    acked = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.ldr_ack === 1'b1 || bus.cpu_ack === 1'b1) begin acked = 1'b1; break; end
    end
    total++; if (!acked) begin bad++; $display("FAIL starve_final_ack got=0 exp=1"); end
    bus.cpu_req = 1'b0; bus.ldr_req = 1'b0;
    @(negedge clk);
    total++; if (bus.ldr_rdata !== 8'h3C) begin bad++; $display("FAIL ldr_rd_data got=%h exp=3c", bus.ldr_rdata); end
  endtask

  task automatic test_lock;
    int exp_seq [5] = '{2, 2, 2, 1, 2};
    int seq [5];
    int n, nl;
    bit cpu_done;
    bus.run = 1'b1;
    bus.ldr_req = 1'b1; bus.ldr_we = 1'b1; bus.ldr_lock = 1'b1; bus.ldr_addr = 8'h20; bus.ldr_wdata = 8'h50;
    @(negedge clk);
    total++; if (bus.owner !== 2'b10) begin bad++; $display("FAIL lock_first_owner got=%b exp=10", bus.owner); end
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 8'h05;
    n = 0; nl = 0; cpu_done = 1'b0;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (bus.ldr_ack === 1'b1 && n < 5) begin
        seq[n] = 2; n++; nl++;
        bus.ldr_addr = 8'(32 + nl); bus.ldr_wdata = 8'(80 + nl);
        if (nl == 3) bus.ldr_lock = 1'b0;
        if (nl == 4) bus.ldr_req = 1'b0;
      end
      if (bus.cpu_ack === 1'b1 && n < 5) begin
        seq[n] = 1; n++; cpu_done = 1'b1; bus.cpu_req = 1'b0;
      end
      if (nl >= 4 && cpu_done) break;
    end
    total++; if (n !== 5) begin bad++; $display("FAIL lock_ack_count got=%0d exp=5", n); end
    for (int i = 0; i < n; i++) begin
      total++; if (seq[i] !== exp_seq[i]) begin
        bad++; $display("FAIL lock_ack_%0d got=%0d exp=%0d", i, seq[i], exp_seq[i]); end
    end
    total++; if ({ram[8'h20], ram[8'h22], ram[8'h23]} !== 24'h505253) begin
      bad++; $display("FAIL lock_ram got=%h exp=505253", {ram[8'h20], ram[8'h22], ram[8'h23]}); end
    bus.cpu_req = 1'b0; bus.ldr_req = 1'b0; bus.ldr_lock = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_async_reset;
    int lat, en_cnt;
    bit ack_in_rst;
    bus.run = 1'b1;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 8'h0F;
    @(negedge clk);
    @(negedge clk);
    total++; if (bus.owner !== 2'b01) begin bad++; $display("FAIL rst_pre_owner got=%b exp=01", bus.owner); end
    #1 clr_n = 1'b0;
    #1;
    total++; if ({bus.mem_en, bus.owner, bus.cpu_ack} !== 4'b0000) begin
      bad++; $display("FAIL rst_async got=%b exp=0000", {bus.mem_en, bus.owner, bus.cpu_ack}); end
    total++; if (bus.cpu_rdata !== 8'h00) begin bad++; $display("FAIL rst_async_rdata got=%h exp=00", bus.cpu_rdata); end
    ack_in_rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (bus.cpu_ack === 1'b1 || bus.mem_en === 1'b1) ack_in_rst = 1'b1;
    end
    total++; if (ack_in_rst) begin bad++; $display("FAIL rst_hold_quiet got=1 exp=0"); end
    clr_n = 1'b1;
    lat = -1; en_cnt = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (bus.mem_en === 1'b1) en_cnt++;
      if (bus.cpu_ack === 1'b1) begin lat = i; break; end
    end
    total++; if (lat !== 3 || en_cnt !== 1) begin
      bad++; $display("FAIL rst_fresh_access got=lat%0d/en%0d exp=lat3/en1", lat, en_cnt); end
    total++; if (bus.cpu_rdata !== 8'hA7) begin bad++; $display("FAIL rst_fresh_data got=%h exp=a7", bus.cpu_rdata); end
    bus.cpu_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_ldr_write_cpu_read();
    test_program_block();
    test_starve();
    test_lock();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_arb.md
Name: ram_arb

Overview:
- Arbitrates the single-port program/data RAM between two requesters:
  - the CPU control unit (instruction fetch, LDA/ADD/STA/LDX operand accesses);
  - the front-panel program loader.
- Sits between both requesters and the RAM macro.
- Serialises accesses through a registered FSM.
- Enforces run/program mode and prevents loader starvation.

Parameters:
- AW, 8, address width.
- DW, 8, data width.
- STARVE, 4, consecutive CPU grants a waiting loader tolerates in run mode (1..15).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- clr_n  in  1  reset, asynchronous, active-low.
- run  in  1  1 = run mode (CPU priority), 0 = program mode (CPU never granted).
- cpu_req  in  1  CPU access request, held until cpu_ack.
- cpu_we  in  1  CPU write enable.
- cpu_addr  in  AW  CPU address.
- cpu_wdata  in  DW  CPU write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  DW  CPU read data, valid with cpu_ack.
- ldr_req  in  1  loader request, held until ldr_ack.
- ldr_we  in  1  loader write enable.
- ldr_addr  in  AW  loader address.
- ldr_wdata  in  DW  loader write data.
- ldr_lock  in  1  keep loader ownership across back-to-back transactions.
- ldr_ack  out  1  one-cycle completion pulse.
- ldr_rdata  out  DW  loader read data, valid with ldr_ack.
- mem_en  out  1  RAM access strobe.
- mem_we  out  1  RAM write enable.
- mem_addr  out  AW  RAM address.
- mem_wdata  out  DW  RAM write data.
- mem_rdata  in  DW  RAM read data, one cycle after mem_en (synchronous RAM).
- owner  out  2  00 none, 01 CPU, 10 loader; current transaction owner.

Behaviour:
- Reset (clr_n=0, asynchronous):
  - state=IDLE, owner=00.
  - all acks, mem_en and mem_we = 0.
  - mem_addr, mem_wdata, cpu_rdata, ldr_rdata = 0.
  - starve counter = 0, lock flag = 0.
  - Reset mid-transaction aborts it; no ack is issued.
- All outputs are registered.
- FSM states, one state per cycle:
  - IDLE: arbitrate.
  - ACC: mem_en=1; mem_we/addr/wdata taken from the winner.
  - RSP: mem_en=0; the RAM presents data.
  - ACK: the winner's ack=1 for exactly one cycle. On reads, winner's rdata is loaded from mem_rdata sampled at the end of RSP. On writes, rdata is unchanged.
  - ACK always returns to IDLE.
- Latency: req high at IDLE edge → ack asserted in the 3rd cycle after that edge. Back-to-back throughput is one access per 4 cycles.
- Requester contract:
  - req, we, addr and wdata stay stable from req rise until ack.
  - req sampled during ACC/RSP/ACK is ignored for arbitration.
  - The requester drops req, or presents a new request, in the cycle after ack.
- Request fields are latched at the IDLE→ACC edge. Later changes do not affect the current access.
- Arbitration in IDLE, in priority order:
  - Lock: lock flag=1 and ldr_req → loader.
  - Program mode (run=0): ldr_req → loader; cpu_req is held pending, never granted.
  - Run mode, both requesting, starve counter = STARVE → loader.
  - Run mode otherwise: CPU before loader.
- Starve counter (saturating at STARVE):
  - increments on each CPU grant made while ldr_req=1;
  - clears on every loader grant;
  - clears whenever ldr_req=0 in IDLE.
- Lock flag:
  - set at a loader grant with ldr_lock=1;
  - cleared in IDLE when ldr_lock=0 or ldr_req=0.
  - While set, the CPU is not granted, even in run mode.
- owner: set at the IDLE→ACC edge, held through ACK, 00 in IDLE.
- run toggling mid-transaction does not abort the transaction; the new mode applies at the next IDLE.

Test Plan:
- Reset then CPU read:
  - stimulus: RAM[0x05]=0x3C, cpu_req=1, we=0, addr=0x05;
  - response: mem_en pulses 1 cycle with mem_addr=0x05, cpu_ack in 3rd cycle after sample, cpu_rdata=0x3C, owner 01 then 00.
- Loader write then CPU read:
  - stimulus: run=0, ldr write 0xA7 to 0x0F; then run=1, CPU reads 0x0F;
  - response: mem_we=1 only during the loader ACC cycle; cpu_rdata=0xA7; ldr_rdata unchanged (0).
- Program mode blocking:
  - stimulus: run=0, cpu_req held high 20 cycles;
  - response: no cpu_ack, mem_en never 1. Raising run=1 → cpu_ack within 4 cycles.
- Starvation guard:
  - stimulus: run=1, both requesters continuously re-requesting, STARVE=4;
  - response: grant sequence CPU,CPU,CPU,CPU,LDR,CPU×4,LDR…
- Lock burst:
  - stimulus: run=1, ldr_lock=1, loader issues 3 back-to-back writes while cpu_req=1;
  - response: 3 loader acks before any cpu_ack. Dropping ldr_lock → CPU wins the next IDLE.
- Async reset mid-access:
  - stimulus: clr_n=0 during RSP of a CPU read;
  - response: immediately mem_en=0, owner=00, no cpu_ack. After release, cpu_req still high → a fresh full 4-cycle access.
